// File: rtl/unidad_de_riesgos.sv
// Hazard and forwarding controller for the 5-stage pipeline: ALU operand forwarding,
// load-use stalls with configurable latency, branch flushes and saturating perf counters.
module unidad_de_riesgos #(
   parameter int REG_ADDR_W   = 5,
   parameter int CNT_W        = 16,
   parameter int LOAD_LAT     = 1,
   parameter int BRANCH_STAGE = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  ex_memRead,
   input  logic [REG_ADDR_W-1:0] ex_wr_addr,
   input  logic                  mem_regWrite,
   input  logic [REG_ADDR_W-1:0] mem_wr_addr,
   input  logic                  wb_regWrite,
   input  logic [REG_ADDR_W-1:0] wb_wr_addr,
   input  logic                  br_taken,
   input  logic                  clr_counts,
   output logic                  o_pc_write,
   output logic                  o_if_id_write,
   output logic                  o_id_ex_bubble,
   output logic                  o_flush_if_id,
   output logic                  o_flush_id_ex,
   output logic                  o_flush_ex_mem,
   output logic [1:0]            o_fwd_a,
   output logic [1:0]            o_fwd_b,
   output logic                  o_stalled,
   output logic [CNT_W-1:0]      o_stall_count,
   output logic [CNT_W-1:0]      o_flush_count
);

   typedef enum logic {RUN, STALL} state_t;

   state_t     state, next_state;
   logic [2:0] remaining, next_remaining;
   logic [1:0] fwd_a, fwd_b;
   logic       hz;
   logic       stall_cycle;

   // MEM stage holds the youngest result, so it wins over WB; r0 is hardwired zero.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (mem_regWrite && mem_wr_addr != '0 && mem_wr_addr == ex_rs)
         fwd_a = 2'b10;
      else if (wb_regWrite && wb_wr_addr != '0 && wb_wr_addr == ex_rs)
         fwd_a = 2'b01;
      if (mem_regWrite && mem_wr_addr != '0 && mem_wr_addr == ex_rt)
         fwd_b = 2'b10;
      else if (wb_regWrite && wb_wr_addr != '0 && wb_wr_addr == ex_rt)
         fwd_b = 2'b01;
   end

   assign hz = ex_memRead && (ex_wr_addr != '0) &&
               ((id_uses_rs && id_rs == ex_wr_addr) || (id_uses_rt && id_rt == ex_wr_addr));

   // A taken branch squashes the stalled instruction, so it never counts as a stall cycle.
   assign stall_cycle = !br_taken && ((state == STALL) || hz);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         remaining <= 3'd0;
      end else begin
         state     <= next_state;
         remaining <= next_remaining;
      end
   end

   always_comb begin
      next_state     = state;
      next_remaining = remaining;
      if (br_taken) begin
         next_state     = RUN;
         next_remaining = 3'd0;
      end else begin
         case (state)
            RUN: begin
               if (hz && LOAD_LAT > 1) begin
                  next_state     = STALL;
                  next_remaining = 3'(LOAD_LAT - 1);
               end
            end
            STALL: begin
               if (remaining <= 3'd1) begin
                  next_state     = RUN;
                  next_remaining = 3'd0;
               end else begin
                  next_remaining = remaining - 3'd1;
               end
            end
            default: begin
               next_state     = RUN;
               next_remaining = 3'd0;
            end
         endcase
      end
   end

   // Outputs are forced low while reset is held, independent of the clock.
   always_comb begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b0;
      o_flush_if_id  = 1'b0;
      o_flush_id_ex  = 1'b0;
      o_flush_ex_mem = 1'b0;
      o_fwd_a        = 2'b00;
      o_fwd_b        = 2'b00;
      o_stalled      = 1'b0;
      if (reset) begin
         o_fwd_a   = fwd_a;
         o_fwd_b   = fwd_b;
         o_stalled = (state == STALL);
         if (br_taken) begin
            o_pc_write     = 1'b1;
            o_if_id_write  = 1'b1;
            o_flush_if_id  = 1'b1;
            o_flush_id_ex  = (BRANCH_STAGE >= 2);
            o_flush_ex_mem = (BRANCH_STAGE == 3);
         end else if (stall_cycle) begin
            o_id_ex_bubble = 1'b1;
         end else begin
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_stall_count <= '0;
         o_flush_count <= '0;
      end else if (clr_counts) begin
         o_stall_count <= '0;
         o_flush_count <= '0;
      end else begin
         if (stall_cycle && o_stall_count != '1)
            o_stall_count <= o_stall_count + CNT_W'(1);
         if (br_taken && o_flush_count != '1)
            o_flush_count <= o_flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_unidad_de_riesgos.sv
// Bench for unidad_de_riesgos: three instances with different latency / branch stage /
// counter width share the same stimulus and are checked against a cycle-level model.
module tb_unidad_de_riesgos;

   localparam int N = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr_addr, mem_wr_addr, wb_wr_addr;
   logic       id_uses_rs, id_uses_rt, ex_memRead, mem_regWrite, wb_regWrite;
   logic       br_taken, clr_counts;

   logic [10:0] out_vec   [N];
   logic [15:0] stall_cnt [N];
   logic [15:0] flush_cnt [N];

   int checks   = 0;
   int failures = 0;

   int freeze_left [N];
   int m_scnt      [N];
   int m_fcnt      [N];

   always #5 clk = ~clk;

   // Output vector layout: pc_write, if_id_write, bubble, flush_if_id, flush_id_ex,
   // flush_ex_mem, fwd_a[1:0], fwd_b[1:0], stalled.
   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
      localparam int BS  = (g == 2) ? 1 : 3;
      localparam int CW  = (g == 2) ? 4 : 16;
      logic          pw, ifw, bub, f1, f2, f3, st;
      logic [1:0]    fa, fb;
      logic [CW-1:0] sc, fc;

      unidad_de_riesgos #(
         .REG_ADDR_W(5), .CNT_W(CW), .LOAD_LAT(LAT), .BRANCH_STAGE(BS)
      ) u_dut (
         .clk(clk), .reset(reset),
         .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
         .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memRead(ex_memRead), .ex_wr_addr(ex_wr_addr),
         .mem_regWrite(mem_regWrite), .mem_wr_addr(mem_wr_addr),
         .wb_regWrite(wb_regWrite), .wb_wr_addr(wb_wr_addr),
         .br_taken(br_taken), .clr_counts(clr_counts),
         .o_pc_write(pw), .o_if_id_write(ifw), .o_id_ex_bubble(bub),
         .o_flush_if_id(f1), .o_flush_id_ex(f2), .o_flush_ex_mem(f3),
         .o_fwd_a(fa), .o_fwd_b(fb), .o_stalled(st),
         .o_stall_count(sc), .o_flush_count(fc)
      );

      assign out_vec[g]   = {pw, ifw, bub, f1, f2, f3, fa, fb, st};
      assign stall_cnt[g] = 16'(sc);
      assign flush_cnt[g] = 16'(fc);
   end

   function automatic int lat_of(int k);
      return (k == 0) ? 1 : (k == 1) ? 3 : 4;
   endfunction

   function automatic int bs_of(int k);
      return (k == 2) ? 1 : 3;
   endfunction

   function automatic int sat_inc(int v, int k);
      int top;
      top = (k == 2) ? 15 : 65535;
      return (v < top) ? v + 1 : v;
   endfunction

   function automatic logic [1:0] fwd_model(logic [4:0] src);
      if (mem_regWrite && mem_wr_addr != 0 && mem_wr_addr == src) return 2'b10;
      if (wb_regWrite && wb_wr_addr != 0 && wb_wr_addr == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic hz_model();
      return ex_memRead && ex_wr_addr != 0 &&
             ((id_uses_rs && id_rs == ex_wr_addr) || (id_uses_rt && id_rt == ex_wr_addr));
   endfunction

   // freeze_left counts the freeze cycles still owed by a load-use hazard after this one.
   function automatic logic [10:0] exp_out(int k);
      logic pw, ifw, bub, f1, f2, f3, st;
      if (!reset) return 11'd0;
      pw = 1'b1; ifw = 1'b1; bub = 1'b0; f1 = 1'b0; f2 = 1'b0; f3 = 1'b0;
      st = (freeze_left[k] > 0);
      if (br_taken) begin
         f1 = 1'b1;
         f2 = (bs_of(k) >= 2);
         f3 = (bs_of(k) == 3);
      end else if (freeze_left[k] > 0 || hz_model()) begin
         pw = 1'b0; ifw = 1'b0; bub = 1'b1;
      end
      return {pw, ifw, bub, f1, f2, f3, fwd_model(ex_rs), fwd_model(ex_rt), st};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         freeze_left[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < N; k++) begin
         if (!reset) begin
            freeze_left[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
         end else begin
            if (br_taken) begin
               freeze_left[k] = 0;
               m_fcnt[k] = sat_inc(m_fcnt[k], k);
            end else if (freeze_left[k] > 0) begin
               freeze_left[k]--;
               m_scnt[k] = sat_inc(m_scnt[k], k);
            end else if (hz_model()) begin
               freeze_left[k] = lat_of(k) - 1;
               m_scnt[k] = sat_inc(m_scnt[k], k);
            end
            if (clr_counts) begin
               m_scnt[k] = 0; m_fcnt[k] = 0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_idle();
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      ex_rs = 0; ex_rt = 0; ex_memRead = 0; ex_wr_addr = 0;
      mem_regWrite = 0; mem_wr_addr = 0; wb_regWrite = 0; wb_wr_addr = 0;
      br_taken = 0; clr_counts = 0;
   endtask

   task automatic set_hazard();
      set_idle();
      ex_memRead = 1; ex_wr_addr = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_idle();
      model_reset();
      for (int c = 0; c < 4; c++) begin
         if (c == 2) reset = 1'b1;
         if (c == 3) set_hazard();
         #1;
         for (int k = 0; k < N; k++) begin
            checks++;
            if (out_vec[k] !== exp_out(k)) begin
               failures++;
               $display("[TB] FAIL reset inst%0d cyc%0d outputs got=%b want=%b", k, c, out_vec[k], exp_out(k));
            end
            checks++;
            if ({stall_cnt[k], flush_cnt[k]} !== {16'(m_scnt[k]), 16'(m_fcnt[k])}) begin
               failures++;
               $display("[TB] FAIL reset inst%0d counts got=%0d/%0d want=%0d/%0d", k, stall_cnt[k], flush_cnt[k], m_scnt[k], m_fcnt[k]);
            end
         end
         tick();
      end
      set_idle();
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_vec[1] !== 11'd0 || stall_cnt[1] !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_mid_stall got=%b/%0d want=0/0", out_vec[1], stall_cnt[1]);
      end
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (out_vec[1][10] !== 1'b1 || out_vec[1][0] !== 1'b0 || stall_cnt[1] !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_release got=%b/%0d want pc_write=1 stalled=0 count=0", out_vec[1], stall_cnt[1]);
      end
      tick();
   endtask

   task automatic test_forwarding();
      logic [1:0] want_a [3];
      want_a[0] = 2'b10; want_a[1] = 2'b01; want_a[2] = 2'b00;
      set_idle();
      mem_regWrite = 1; mem_wr_addr = 5; wb_regWrite = 1; wb_wr_addr = 5; ex_rs = 5;
      for (int s = 0; s < 3; s++) begin
         if (s == 1) mem_wr_addr = 0;
         if (s == 2) wb_regWrite = 0;
         #1;
         checks++;
         if (out_vec[0][4:3] !== want_a[s]) begin
            failures++;
            $display("[TB] FAIL fwd_directed step%0d got=%b want=%b", s, out_vec[0][4:3], want_a[s]);
         end
      end
      tick();
      for (int i = 0; i < 40; i++) begin
         ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
         mem_regWrite = 1'($urandom); mem_wr_addr = 5'($urandom_range(0, 3));
         wb_regWrite = 1'($urandom); wb_wr_addr = 5'($urandom_range(0, 3));
         #1;
         for (int k = 0; k < N; k++) begin
            checks++;
            if (out_vec[k] !== exp_out(k)) begin
               failures++;
               $display("[TB] FAIL fwd_random inst%0d got=%b want=%b", k, out_vec[k], exp_out(k));
            end
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      set_idle();
      clr_counts = 1;
      tick();
      set_hazard();
      for (int c = 0; c < 6; c++) begin
         if (c == 1) set_idle();
         #1;
         for (int k = 0; k < N; k++) begin
            checks++;
            if (out_vec[k] !== exp_out(k)) begin
               failures++;
               $display("[TB] FAIL load_use inst%0d cyc%0d got=%b want=%b", k, c, out_vec[k], exp_out(k));
            end
         end
         tick();
      end
      #1;
      checks++;
      if (stall_cnt[0] !== 16'd1 || stall_cnt[1] !== 16'd3 || stall_cnt[2] !== 16'd4) begin
         failures++;
         $display("[TB] FAIL load_use_counts got=%0d/%0d/%0d want=1/3/4", stall_cnt[0], stall_cnt[1], stall_cnt[2]);
      end
   endtask

   task automatic test_branch_during_stall();
      set_idle();
      clr_counts = 1;
      tick();
      set_hazard();
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin set_idle(); br_taken = 1; end
         if (c == 2) set_idle();
         #1;
         for (int k = 0; k < N; k++) begin
            checks++;
            if (out_vec[k] !== exp_out(k)) begin
               failures++;
               $display("[TB] FAIL branch inst%0d cyc%0d got=%b want=%b", k, c, out_vec[k], exp_out(k));
            end
         end
         if (c == 1) begin
            checks++;
            if (out_vec[1][10] !== 1'b1 || out_vec[1][7:5] !== 3'b111 || out_vec[1][8] !== 1'b0) begin
               failures++;
               $display("[TB] FAIL branch_flush got=%b want pc_write=1 flushes=111 bubble=0", out_vec[1]);
            end
         end
         tick();
      end
      #1;
      checks++;
      if (stall_cnt[1] !== 16'd1 || flush_cnt[1] !== 16'd1 || out_vec[1][0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL branch_counts got=%0d/%0d stalled=%b want=1/1 stalled=0", stall_cnt[1], flush_cnt[1], out_vec[1][0]);
      end
   endtask

   task automatic test_saturation();
      set_idle();
      clr_counts = 1;
      tick();
      for (int h = 0; h < 20; h++) begin
         for (int c = 0; c < 5; c++) begin
            if (c == 0) set_hazard(); else set_idle();
            #1;
            for (int k = 0; k < N; k++) begin
               checks++;
               if (stall_cnt[k] !== 16'(m_scnt[k]) || out_vec[k] !== exp_out(k)) begin
                  failures++;
                  $display("[TB] FAIL saturate inst%0d h%0d got=%0d/%b want=%0d/%b", k, h, stall_cnt[k], out_vec[k], m_scnt[k], exp_out(k));
               end
            end
            tick();
         end
      end
      #1;
      checks++;
      if (stall_cnt[2] !== 16'd15 || stall_cnt[0] !== 16'd20) begin
         failures++;
         $display("[TB] FAIL saturate_hold got=%0d/%0d want=15/20", stall_cnt[2], stall_cnt[0]);
      end
      set_hazard();
      clr_counts = 1;
      tick();
      set_idle();
      #1;
      checks++;
      if (stall_cnt[2] !== 16'd0 || stall_cnt[1] !== 16'd0) begin
         failures++;
         $display("[TB] FAIL clear_counts got=%0d/%0d want=0/0", stall_cnt[2], stall_cnt[1]);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
         ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
         ex_memRead = 1'($urandom); ex_wr_addr = 5'($urandom_range(0, 3));
         mem_regWrite = 1'($urandom); mem_wr_addr = 5'($urandom_range(0, 3));
         wb_regWrite = 1'($urandom); wb_wr_addr = 5'($urandom_range(0, 3));
         br_taken = ($urandom_range(0, 7) == 0);
         clr_counts = ($urandom_range(0, 31) == 0);
         reset = ($urandom_range(0, 63) != 0);
         if (!reset) model_reset();
         #1;
         for (int k = 0; k < N; k++) begin
            checks++;
            if (out_vec[k] !== exp_out(k)) begin
               failures++;
               $display("[TB] FAIL random inst%0d i%0d outputs got=%b want=%b", k, i, out_vec[k], exp_out(k));
            end
            checks++;
            if ({stall_cnt[k], flush_cnt[k]} !== {16'(m_scnt[k]), 16'(m_fcnt[k])}) begin
               failures++;
               $display("[TB] FAIL random inst%0d i%0d counts got=%0d/%0d want=%0d/%0d", k, i, stall_cnt[k], flush_cnt[k], m_scnt[k], m_fcnt[k]);
            end
         end
         tick();
      end
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_during_stall();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
